port_rd_frontend: RTL

- Per-output-port read-side frontend, one instance per port (16 total).
- Selects a non-empty priority queue (strict or WRR) and requests a packet dequeue from the SRAM read path.
- Buffers the returned data words in a small FIFO and drives the port's rd_sop/rd_vld/rd_data/rd_eop stream.
- Counterpart of the write-side frontend.

---
 rtl/hydra_pkg.sv | 28 ++
 rtl/rd_prior_arbiter.sv | 44 ++++
 rtl/port_rd_frontend.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the read-side port frontend.
package hydra_pkg;

  localparam int PRIOR_NUM = 8;
  localparam int PORT_NUM  = 16;
  localparam int DATA_W    = 16;
  localparam int CREDIT_W  = 4;

  typedef logic [2:0] prior_t;

  typedef enum logic [2:0] {IDLE, REQ, SOP, DATA, EOP} rd_state_t;

  // Priority p is granted 8-p packets per WRR round.
  function automatic logic [CREDIT_W-1:0] wrr_weight(input int p);
    return CREDIT_W'(PRIOR_NUM - p);
  endfunction

  // Index of the lowest set bit; returns 0 when the vector is empty.
  function automatic prior_t lowest_set(input logic [PRIOR_NUM-1:0] v);
    prior_t idx;
    idx = '0;
    for (int i = PRIOR_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = prior_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rd_prior_arbiter.sv
// Queue selection for one output port: strict priority or weighted round robin
// with per-priority credits, reloaded when no non-empty queue has credit left.
module rd_prior_arbiter
  import hydra_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRIOR_NUM-1:0] queue_empty_i,
  input  logic                 wrr_enable_i,
  input  logic                 select_i,
  input  logic                 consume_i,
  input  prior_t               consume_prior_i,
  output prior_t               sel_prior_o,
  output logic                 sel_valid_o
);

  logic [CREDIT_W-1:0]  credit_q [PRIOR_NUM];
  logic [PRIOR_NUM-1:0] nonempty;
  logic [PRIOR_NUM-1:0] eligible;
  logic                 reload;

  assign nonempty = ~queue_empty_i;

  for (genvar gi = 0; gi < PRIOR_NUM; gi++) begin : g_elig
    assign eligible[gi] = nonempty[gi] && (credit_q[gi] != '0);
  end

  assign sel_valid_o = |nonempty;
  // Exhausted round: refill on the selecting cycle and fall back to strict order.
  assign reload      = select_i && wrr_enable_i && (eligible == '0);
  assign sel_prior_o = (wrr_enable_i && (eligible != '0)) ? lowest_set(eligible)
                                                          : lowest_set(nonempty);

  always_ff @(posedge clk) begin
    for (int p = 0; p < PRIOR_NUM; p++) begin
      if (!rst_n || reload) begin
        credit_q[p] <= wrr_weight(p);
      end else if (consume_i && (consume_prior_i == prior_t'(p)) && (credit_q[p] != '0)) begin
        credit_q[p] <= credit_q[p] - CREDIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/port_rd_frontend.sv
// Per-port read frontend: arbitrates a queue, requests a dequeue, buffers words
// and emits the sop/vld/eop stream. Define RD_STATS_EN to add pkt_sent_cnt.
module port_rd_frontend #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic              wrr_enable,
  input  logic [7:0]        queue_empty,
  output logic              deq_request,
  output logic [2:0]        deq_prior,
  input  logic              deq_grant,
  input  logic              xfer_data_vld,
  input  logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_end,
  output logic              xfer_ready,
  output logic              rd_sop,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eop
`ifdef RD_STATS_EN
  ,
  output logic [15:0]       pkt_sent_cnt
`endif
);
  import hydra_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  rd_state_t         state_q, state_d;
  prior_t            prior_q, prior_d;
  logic              deq_request_q, deq_request_d;
  logic              rd_sop_q, rd_sop_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_eop_q, rd_eop_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              xfer_ready_q, xfer_ready_d;

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W:0]   head;
  logic              push, pop, full;

  prior_t            sel_prior;
  logic              sel_valid, arb_select, arb_consume;

  rd_prior_arbiter u_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .queue_empty_i   (queue_empty),
    .wrr_enable_i    (wrr_enable),
    .select_i        (arb_select),
    .consume_i       (arb_consume),
    .consume_prior_i (prior_q),
    .sel_prior_o     (sel_prior),
    .sel_valid_o     (sel_valid)
  );

  assign head = fifo_mem[rd_ptr_q];
  assign full = (count_q == CW'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    prior_d       = prior_q;
    deq_request_d = deq_request_q;
    rd_sop_d      = 1'b0;
    rd_vld_d      = 1'b0;
    rd_eop_d      = 1'b0;
    rd_data_d     = rd_data_q;
    arb_select    = 1'b0;
    arb_consume   = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready && sel_valid) begin
          arb_select    = 1'b1;
          prior_d       = sel_prior;
          deq_request_d = 1'b1;
          state_d       = REQ;
        end
      end
      REQ: begin
        if (deq_grant) begin
          deq_request_d = 1'b0;
          arb_consume   = 1'b1;
          rd_sop_d      = 1'b1;
          state_d       = SOP;
        end
      end
      SOP: state_d = DATA;
      DATA: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          rd_vld_d  = 1'b1;
          rd_data_d = head[DATA_W-1:0];
          if (head[DATA_W]) state_d = EOP;
        end
      end
      // rd_eop lands one cycle after the last rd_vld.
      EOP: begin
        rd_eop_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push     = xfer_data_vld && !full && (state_q inside {REQ, SOP, DATA});
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // One slot of slack covers the word already in flight when ready drops.
    xfer_ready_d = (count_d <= CW'(FIFO_DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prior_q       <= '0;
      deq_request_q <= 1'b0;
      rd_sop_q      <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_eop_q      <= 1'b0;
      rd_data_q     <= '0;
      xfer_ready_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      prior_q       <= prior_d;
      deq_request_q <= deq_request_d;
      rd_sop_q      <= rd_sop_d;
      rd_vld_q      <= rd_vld_d;
      rd_eop_q      <= rd_eop_d;
      rd_data_q     <= rd_data_d;
      xfer_ready_q  <= xfer_ready_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_mem[wr_ptr_q] <= {xfer_end, xfer_data};
  end

  assign deq_request = deq_request_q;
  assign deq_prior   = prior_q;
  assign rd_sop      = rd_sop_q;
  assign rd_vld      = rd_vld_q;
  assign rd_data     = rd_data_q;
  assign rd_eop      = rd_eop_q;
  assign xfer_ready  = xfer_ready_q;

`ifdef RD_STATS_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)        pkt_cnt_q <= '0;
    else if (rd_eop_d) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign pkt_sent_cnt = pkt_cnt_q;
`endif

endmodule
